pdm_audio_tx: RTL
=================

Name: pdm_audio_tx

Overview:
Transmit-side counterpart of the microphone PDM decimator: converts 8-bit signed 12 kHz samples back into a 1-bit pulse-density stream at 3.072 MHz for speaker/audio-out playback of recordings.
Samples enter over a valid/ready handshake into a small FIFO. A first-order sigma-delta modulator then emits OSR PDM bits per sample.
Runs on clk_m (98.3 MHz): 98.3 MHz / 32 = 3.072 MHz bit rate; 3.072 MHz / 256 = 12 kHz sample rate, matching the receiver.

Parameters:
SAMPLE_W, 8, sample width (two's complement)
FIFO_DEPTH, 16, sample FIFO entries (power of 2)
STEP_PERIOD, 32, clk_in cycles per PDM bit (even, >=4)
OSR, 256, PDM bits per sample

Ports:
clk_in  in  1  system clock (clk_m)
rst_in  in  1  synchronous active-high reset
sample_in  in  SAMPLE_W  signed audio sample
sample_valid_in  in  1  sample_in is valid
sample_ready_out  out  1  FIFO can accept; a transfer occurs when valid && ready
enable_in  in  1  playback enable
pdm_out  out  1  PDM data bit
pdm_clk_out  out  1  bit clock, STEP_PERIOD cycles per period, 50% duty
underflow_out  out  1  single-cycle pulse: sample boundary reached with FIFO empty
fifo_count_out  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (any cycle, including mid-sample) clears the following: FIFO empty, count 0, step_cnt 0, bit_cnt 0, accumulator 0, cur_sample 8'h80 (silence).
- Reset values of outputs: pdm_out 0, pdm_clk_out 0, underflow_out 0, sample_ready_out 1, fifo_count_out 0.
- sample_ready_out = (count < FIFO_DEPTH), combinational from the count register. A push with ready low is ignored.
- step_cnt counts 0..STEP_PERIOD-1 and wraps while enable_in=1. step = enable_in && step_cnt==STEP_PERIOD-1.
- pdm_clk_out is registered and equals (step_cnt < STEP_PERIOD/2). While enable_in=0, it is held 0.
- On step:
  - If bit_cnt==0, load cur_sample. The load pops the FIFO head if non-empty. If empty, it loads 8'h80 and pulses underflow_out that cycle.
  - The loaded value is used for this same bit (muxed through).
  - u = offset-binary of the active sample = {~s[7], s[6:0]}.
  - {carry, acc} <= acc + u (9-bit sum).
  - pdm_out <= carry.
  - bit_cnt <= (bit_cnt==OSR-1) ? 0 : bit_cnt+1.
- The accumulator is not cleared at sample boundaries, only by reset.
- Latency: pdm_out changes 1 cycle after the step cycle, i.e. at the pdm_clk_out rising edge.
- Simultaneous push and pop: both take effect and count is unchanged.
  - Full + pop + push: the push is refused because ready was low that cycle.
  - Empty + push + pop on the same cycle: no bypass. Pop sees empty, so underflow fires and silence is loaded; the pushed sample is stored.
- enable_in=0:
  - step_cnt, bit_cnt, pdm_out and pdm_clk_out are forced to 0; acc is held.
  - The FIFO still accepts pushes.
  - When enable rises, the first step (STEP_PERIOD cycles later) starts a new sample.
- Density: over one sample, number of ones = floor((acc0 + OSR*u)/256) - floor(acc0/256) for OSR=256.

Decomposition:
- audio_pkg holds:
  - SAMPLE_W
  - SILENCE_OFFSET = 8'h80
  - PDM_STEP_PERIOD = 32
  - PDM_OSR = 256
  - function to_offset_binary(s)
- The microphone decimator reuses the same constants.
- One sub-module: sync_sample_fifo (sync FIFO with push/pop/count/full/empty, no bypass, write-ignored-when-full). It is instantiated once.

Test Plan:
- Reset mid-playback (after 100 bits) -> next cycle: pdm_out=0, pdm_clk_out=0, fifo_count_out=0, sample_ready_out=1, underflow_out=0.
- From reset, push 8'h00, enable -> first 256 bits contain exactly 128 ones, alternating 0,1,0,1 (acc 128,0,...).
- Push 8'h7F then 8'h80 -> first frame has 255 ones (only bit 0 low); second frame has 0 ones (acc remainder 0 so all 0).
- enable=0, push 20 samples back-to-back -> 16 accepted, ready low from 16th handshake on, count=16. Then enable -> count drops to 15 on first step, and ready rises the same cycle.
- enable with empty FIFO -> underflow_out one-cycle pulse every 8192 cycles, 128 ones per 256 bits. Push one sample mid-frame -> no underflow at the next boundary, and the sample plays.
- Empty FIFO, push coincides with the boundary step -> underflow pulses and silence plays; the pushed sample plays in the next frame, count 1 -> 0 at the next boundary.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio constants and helpers for the PDM transmit and decimator paths.
// Samples are two's complement; the modulator works on offset-binary levels.
package audio_pkg;

  localparam int SAMPLE_W        = 8;
  localparam int PDM_STEP_PERIOD = 32;
  localparam int PDM_OSR         = 256;

  // Mid-scale offset-binary level: equal density of ones and zeros.
  localparam logic [SAMPLE_W-1:0] SILENCE_OFFSET = 8'h80;

  function automatic logic [SAMPLE_W-1:0] to_offset_binary(input logic [SAMPLE_W-1:0] s);
    return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
  endfunction

endpackage

// File: rtl/sync_sample_fifo.sv
// Single-clock sample FIFO, head visible combinationally; count/full/empty from registers.
// No bypass: a push into an empty FIFO is poppable the next cycle. Pushes when full are dropped.
module sync_sample_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic [W-1:0]           pop_dat,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/pdm_audio_tx.sv
// Sample FIFO feeding a first-order sigma-delta modulator: OSR PDM bits per sample, one every STEP_PERIOD clocks.
// pdm_out updates the cycle after each step (with pdm_clk_out rising); sample_ready_out drops only when the FIFO is full.
module pdm_audio_tx #(
  parameter int SAMPLE_W    = audio_pkg::SAMPLE_W,
  parameter int FIFO_DEPTH  = 16,
  parameter int STEP_PERIOD = audio_pkg::PDM_STEP_PERIOD,
  parameter int OSR         = audio_pkg::PDM_OSR
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [SAMPLE_W-1:0]         sample_in,
  input  logic                        sample_valid_in,
  output logic                        sample_ready_out,
  input  logic                        enable_in,
  output logic                        pdm_out,
  output logic                        pdm_clk_out,
  output logic                        underflow_out,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_out
);
  import audio_pkg::*;

  localparam int SW = $clog2(STEP_PERIOD);
  localparam int BW = $clog2(OSR);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_PERIOD - 1);
  localparam logic [SW-1:0] STEP_HALF = SW'(STEP_PERIOD / 2);
  localparam logic [BW-1:0] BIT_LAST  = BW'(OSR - 1);

  logic [SW-1:0]       step_cnt;
  logic [SW-1:0]       step_nxt;
  logic [BW-1:0]       bit_cnt;
  logic [SAMPLE_W-1:0] acc;
  logic [SAMPLE_W-1:0] cur_u;
  logic [SAMPLE_W-1:0] act_u;
  logic [SAMPLE_W-1:0] head;
  logic [SAMPLE_W:0]   sum;
  logic                step;
  logic                boundary;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;

  sync_sample_fifo #(
    .W     (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk_in),
    .rst      (rst_in),
    .push     (sample_valid_in),
    .push_dat (sample_in),
    .pop      (pop),
    .pop_dat  (head),
    .count    (fifo_count_out),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign sample_ready_out = !fifo_full;

  // cur_u holds the playing sample already in offset-binary, so its reset value is silence.
  always_comb begin
    step          = enable_in && (step_cnt == STEP_LAST);
    boundary      = step && (bit_cnt == '0);
    pop           = boundary && !fifo_empty;
    underflow_out = boundary && fifo_empty && !rst_in;
    step_nxt      = step ? '0 : step_cnt + 1'b1;
    act_u         = cur_u;
    if (boundary) act_u = fifo_empty ? SILENCE_OFFSET : to_offset_binary(head);
    sum           = {1'b0, acc} + {1'b0, act_u};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      step_cnt    <= '0;
      bit_cnt     <= '0;
      acc         <= '0;
      cur_u       <= SILENCE_OFFSET;
      pdm_out     <= 1'b0;
      pdm_clk_out <= 1'b0;
    end else if (!enable_in) begin
      step_cnt    <= '0;
      bit_cnt     <= '0;
      pdm_out     <= 1'b0;
      pdm_clk_out <= 1'b0;
    end else begin
      step_cnt    <= step_nxt;
      pdm_clk_out <= (step_nxt < STEP_HALF);
      if (step) begin
        cur_u   <= act_u;
        acc     <= sum[SAMPLE_W-1:0];
        pdm_out <= sum[SAMPLE_W];
        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      end
    end
  end

endmodule
